// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// No logic; imported by dmem_array and dmem_responder.
// Holds the FSM state enum, bus widths, default depth and the address check.
package dmem_pkg;

  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned BE_W                = DATA_W / 8;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DEPTH_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Response payload held stable while the initiator stalls.
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  // A request is in error when it is not word aligned or its word index lies
  // beyond the storage. The index is widened so the compare never truncates.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input int unsigned       depth_words);
    logic [ADDR_W-1:0] word_idx;
    word_idx = {2'b00, addr[ADDR_W-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(depth_words));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with one synchronous byte-enabled write port and one read port.
// Latency: write lands on the clock edge; read data is combinational from the index.
// Backpressure: none, both ports are always available.
//
// Ports:
//   clk        clock
//   wr_en_i    write strobe, wr_idx_i/wr_data_i/wr_be_i sampled on the edge
//   rd_idx_i   word index to read, rd_data_o returns that word
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [BE_W-1:0]   wr_be_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // Read is taken before the write lands, so a read of the word being
  // written on the same edge would see the old contents.
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with valid/ready request and response channels.
// Latency: response valid 1+WAIT_STATES cycles after the accepting edge.
// Backpressure: response held stable until rsp_ready; no new request accepted meanwhile.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_we, req_addr, req_wdata, req_be
//                         sampled on the accepting edge
//   rsp_valid/rsp_ready   response handshake; rsp_rdata (0 for writes/errors),
//                         rsp_err (misaligned or out-of-range request)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Counter preload; only meaningful when there is at least one wait state.
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  rsp_t             rsp_q, rsp_d;

  logic              accept;
  logic              req_err;
  logic              wr_en;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rd_data;

  assign accept   = req_valid & req_ready_q;
  assign req_err  = addr_err(req_addr, DEPTH_WORDS);
  assign word_idx = req_addr[IDX_W+1:2];
  // Erroneous requests never reach storage.
  assign wr_en    = accept & req_we & ~req_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_idx_i  (word_idx),
    .wr_data_i (req_wdata),
    .wr_be_i   (req_be),
    .rd_idx_i  (word_idx),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Response payload is fixed at acceptance, so later writes or
          // input changes cannot disturb it.
          rsp_d.err   = req_err;
          rsp_d.rdata = (req_err || req_we) ? '0 : rd_data;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Both handshake outputs are registered images of the next state. The
    // ready flag comes up one edge after reset release because reset clears
    // it while the state register already reads IDLE.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances (WAIT_STATES 1, 0, 3).
// Directed vector table, hand-written corner sequences, randomized traffic vs a word-array model.
// Responses are stalled randomly to exercise backpressure.
module tb_dmem_responder;

  localparam int NI = 3;
  int WS_TAB    [NI] = '{1, 0, 3};
  int DEPTH_TAB [NI] = '{1024, 1024, 64};

  logic        clk = 1'b0;
  logic        reset     [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference storage: plain word array per instance.
  logic [31:0] mmem [NI][1024];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut2 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural rule: error if not word aligned or word index past the depth;
  // errors and writes return zero; writes merge enabled bytes.
  task automatic model_txn(input int k, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] rd, output logic err);
    longint unsigned widx;
    widx = longint'(addr) / 4;
    err  = (addr % 4 != 0) || (widx >= longint'(DEPTH_TAB[k]));
    rd   = 32'h0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mmem[k][int'(widx)][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rd = mmem[k][int'(widx)];
      end
    end
  endtask

  // One full transaction. hold = number of response cycles with rsp_ready low
  // (0 means rsp_ready is already high when the response appears).
  task automatic do_txn(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        input logic [31:0] exp_rd, input logic exp_err, input string nm,
                        output int acc);
    int   n;
    logic busy_ok;
    busy_ok      = 1'b1;
    acc          = cyc;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    req_valid[k] = 1'b1;
    rsp_ready[k] = (hold == 0);
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (req_ready[k] !== 1'b1) begin
      check({nm, " accept timeout"}, req_ready[k], 1);
      req_valid[k] = 1'b0;
      return;
    end
    tick();
    acc = cyc;
    // Scramble the request bus so late sampling would be caught.
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_be[k]    = 4'($urandom);
    n = 1;
    while (rsp_valid[k] !== 1'b1 && n < 40) begin
      if (req_ready[k] !== 1'b0) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({nm, " latency"}, n, 1 + WS_TAB[k]);
    if (rsp_valid[k] !== 1'b1) begin
      rsp_ready[k] = 1'b1;
      tick();
      rsp_ready[k] = 1'b0;
      return;
    end
    check({nm, " rdata"}, rsp_rdata[k], exp_rd);
    check({nm, " err"}, rsp_err[k], exp_err);
    for (int i = 1; i < hold; i++) begin
      if (req_ready[k] !== 1'b0) busy_ok = 1'b0;
      tick();
      check({nm, " held valid"}, rsp_valid[k], 1);
      check({nm, " held rdata"}, rsp_rdata[k], exp_rd);
      check({nm, " held err"}, rsp_err[k], exp_err);
    end
    if (req_ready[k] !== 1'b0) busy_ok = 1'b0;
    check({nm, " req_ready low while busy"}, busy_ok, 1);
    rsp_ready[k] = 1'b1;
    tick();
    check({nm, " rsp_valid drops after handshake"}, rsp_valid[k], 0);
    check({nm, " req_ready back after handshake"}, req_ready[k], 1);
    if (hold != 0) rsp_ready[k] = 1'b0;
  endtask

  task automatic rand_txn(input int k, input string nm);
    int          sel, w, idx, hold, acc;
    logic        we, e_err;
    logic [31:0] addr, wdata, e_rd;
    logic [3:0]  be;
    sel = $urandom_range(0, 9);
    w   = $urandom_range(0, 31);
    idx = (w < 16) ? w : DEPTH_TAB[k] - 32 + w;
    if (sel < 6)       addr = 32'(idx * 4);
    else if (sel < 8)  addr = 32'(idx * 4) | 32'($urandom_range(1, 3));
    else if (sel == 8) addr = 32'((DEPTH_TAB[k] + $urandom_range(0, 15)) * 4);
    else               addr = $urandom | 32'h8000_0000;
    we    = 1'($urandom_range(0, 1));
    be    = 4'($urandom);
    wdata = $urandom;
    hold  = $urandom_range(0, 3);
    model_txn(k, we, addr, wdata, be, e_rd, e_err);
    do_txn(k, we, addr, wdata, be, hold, e_rd, e_err, nm, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d_rd;
    logic        d_err;
    int          acc, prev_acc, cnt;

    for (int k = 0; k < NI; k++) begin
      reset[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b0;
    end

    // ---------------- reset state ----------------
    #2;
    for (int k = 0; k < NI; k++) reset[k] = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("inst%0d reset req_ready", k), req_ready[k], 0);
      check($sformatf("inst%0d reset rsp_valid", k), rsp_valid[k], 0);
      check($sformatf("inst%0d reset rsp_rdata", k), rsp_rdata[k], 0);
      check($sformatf("inst%0d reset rsp_err", k), rsp_err[k], 0);
    end
    for (int k = 0; k < NI; k++) reset[k] = 1'b1;
    for (int k = 0; k < NI; k++)
      check($sformatf("inst%0d req_ready before first edge", k), req_ready[k], 0);
    tick();
    for (int k = 0; k < NI; k++)
      check($sformatf("inst%0d req_ready after first edge", k), req_ready[k], 1);

    // ---------------- directed table on inst0 (WAIT_STATES=1) ----------------
    vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0, "wr 0x10"});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "rd 0x10"});
    vecs.push_back('{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0, "wr 0x20 full"});
    vecs.push_back('{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0, "wr 0x20 be5"});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        4'hA, 32'h11BB33DD, 1'b0, "rd 0x20 partial"});
    vecs.push_back('{1'b1, 32'h0,    32'h12345678, 4'hF, 32'h0,        1'b0, "wr 0x0"});
    vecs.push_back('{1'b0, 32'h13,   32'h0,        4'hF, 32'h0,        1'b1, "rd 0x13 misaligned"});
    vecs.push_back('{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, "wr 0x1000 range"});
    vecs.push_back('{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0, "rd 0x0 unchanged"});
    vecs.push_back('{1'b1, 32'h20,   32'h0,        4'h0, 32'h0,        1'b0, "wr 0x20 be0"});
    vecs.push_back('{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0, "rd 0x20 after be0"});
    vecs.push_back('{1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0, "wr last word"});
    vecs.push_back('{1'b0, 32'hFFC,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0, "rd last word"});
    vecs.push_back('{1'b0, 32'h1002, 32'h0,        4'h0, 32'h0,        1'b1, "rd 0x1002"});
    vecs.push_back('{1'b1, 32'h12,   32'h0,        4'hF, 32'h0,        1'b1, "wr 0x12 misaligned"});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "rd 0x10 unchanged"});
    for (int i = 0; i < vecs.size(); i++) begin
      model_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, d_rd, d_err);
      do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].nm, acc);
    end

    // ---------------- backpressure: 5 stalled response cycles ----------------
    model_txn(0, 1'b1, 32'h40, 32'h5A5A0F0F, 4'hF, d_rd, d_err);
    do_txn(0, 1'b1, 32'h40, 32'h5A5A0F0F, 4'hF, 1, 32'h0, 1'b0, "bp wr", acc);
    model_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, d_rd, d_err);
    do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 5, 32'h5A5A0F0F, 1'b0, "bp rd", acc);

    // ---------------- prefill the model-tracked words ----------------
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < 32; w++) begin
        logic [31:0] a, dat;
        a   = 32'(((w < 16) ? w : DEPTH_TAB[k] - 32 + w) * 4);
        dat = $urandom;
        model_txn(k, 1'b1, a, dat, 4'hF, d_rd, d_err);
        do_txn(k, 1'b1, a, dat, 4'hF, $urandom_range(0, 2), d_rd, d_err,
               $sformatf("inst%0d prefill", k), acc);
      end
    end

    // ---------------- WAIT_STATES=0: back-to-back, rsp_ready tied high ----------------
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      model_txn(1, 1'b0, a, 32'h0, 4'h0, d_rd, d_err);
      do_txn(1, 1'b0, a, 32'h0, 4'h0, 0, d_rd, d_err, "ws0 b2b", acc);
      if (i > 0) check("ws0 accept spacing", acc - prev_acc, 2);
      prev_acc = acc;
    end

    // ---------------- reset while in WAIT (inst2, WAIT_STATES=3) ----------------
    req_we[2] = 1'b0; req_addr[2] = 32'hC; req_be[2] = 4'h0; rsp_ready[2] = 1'b0;
    req_valid[2] = 1'b1;
    cnt = 0;
    while (req_ready[2] !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    check("rstwait req_ready before accept", req_ready[2], 1);
    tick();
    req_valid[2] = 1'b0;
    tick();
    check("rstwait in WAIT rsp_valid", rsp_valid[2], 0);
    #1 reset[2] = 1'b0;
    #1;
    check("rstwait async rsp_valid", rsp_valid[2], 0);
    check("rstwait async req_ready", req_ready[2], 0);
    check("rstwait async rsp_rdata", rsp_rdata[2], 0);
    check("rstwait async rsp_err", rsp_err[2], 0);
    tick();
    tick();
    check("rstwait held rsp_valid", rsp_valid[2], 0);
    reset[2] = 1'b1;
    check("rstwait req_ready before edge", req_ready[2], 0);
    tick();
    check("rstwait req_ready after edge", req_ready[2], 1);
    cnt = 0;
    repeat (8) begin
      if (rsp_valid[2] !== 1'b0) cnt++;
      tick();
    end
    check("rstwait no stale response", cnt, 0);
    model_txn(2, 1'b0, 32'hC, 32'h0, 4'h0, d_rd, d_err);
    do_txn(2, 1'b0, 32'hC, 32'h0, 4'h0, 1, d_rd, d_err, "rstwait recovery", acc);

    // ---------------- randomized traffic ----------------
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 60; i++)
        rand_txn(k, $sformatf("inst%0d rand%0d", k, i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage (power of two).
REQ-002 The module SHALL have parameter WAIT_STATES, default 1, giving extra cycles (0..15) between request acceptance and response.
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  input  1  the initiator presents a request.
REQ-006 Port: req_ready  output  1  the responder can accept a request.
REQ-007 Port: req_we  input  1  1 = write, 0 = read.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  write data.
REQ-010 Port: req_be  input  4  byte enables for writes; bit n enables bits 8n+7..8n.
REQ-011 Port: rsp_valid  output  1  a response is presented.
REQ-012 Port: rsp_ready  input  1  the initiator accepts the response.
REQ-013 Port: rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 Port: rsp_err  output  1  the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be registered and equal to 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; address, we, wdata and be are sampled at that edge.
REQ-018 On acceptance, the FSM SHALL go to WAIT with wait counter = WAIT_STATES-1 if WAIT_STATES>0, otherwise directly to RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM goes to RESP on the next edge.
REQ-020 Response latency SHALL be 1+WAIT_STATES cycles from the accepting edge to the first cycle with rsp_valid=1.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL remain stable until the edge where rsp_ready=1; the FSM then returns to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle that a response completes; at most one transaction is outstanding.
REQ-023 An error SHALL be flagged when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS.
REQ-024 An erroneous request SHALL NOT modify storage and SHALL return rsp_err=1 and rsp_rdata=0.
REQ-025 A valid write SHALL update only the enabled bytes at the accepting edge; a write with req_be=0 SHALL return a normal response and change nothing.
REQ-026 A valid read SHALL return the word at req_addr[31:2] as captured at the accepting edge, with req_be ignored.
REQ-027 rsp_valid SHALL be 0 in IDLE and WAIT.

Reset
REQ-028 Asserting reset (low) SHALL immediately force state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and wait counter=0, including mid-transaction; a pending response is discarded.
REQ-029 req_ready SHALL become 1 on the first rising edge after reset deasserts.
REQ-030 Storage contents SHALL NOT be reset.

Structure
REQ-031 Package dmem_pkg SHALL hold the FSM state enum, the address/data width constants and the default DEPTH_WORDS.
REQ-032 Storage SHALL be a sub-module dmem_array with a synchronous byte-enabled write port and a read port; the FSM, error checking and handshake remain in dmem_responder.

Verification
REQ-033 Write then read, WAIT_STATES=1: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> rsp_valid 2 cycles after each accept; rdata=0xDEADBEEF, err=0.
REQ-034 Partial write: the word at 0x20 holds 0x11223344; write 0xAABBCCDD with be=0x5, then read 0x20 -> 0x11BB33DD.
REQ-035 Errors: read 0x13 and, with DEPTH_WORDS=1024, write 0x1000 -> rsp_err=1, rdata=0; a later read of 0x0 shows it unchanged.
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with stable data, req_ready stays 0; the response completes on the first edge with rsp_ready=1.
REQ-037 WAIT_STATES=0: back-to-back reads with rsp_ready tied to 1 -> rsp_valid 1 cycle after each accept, one transaction per 2 cycles.
REQ-038 Reset in WAIT: assert reset during WAIT -> rsp_valid and req_ready go to 0 immediately, with no response after release; req_ready=1 one edge after release.
